// File: rtl/spart_baud_tick_if.sv
// Register-bus and tick bundle of the SPART baud tick generator.
// The master drives the bus and consumes the ticks; the slave is the generator.
interface spart_baud_tick_if #(
  parameter int OSR = 16
);
  localparam int PW = $clog2(OSR);

  logic          en;
  logic [1:0]    ioaddr;
  logic          wr;
  logic [7:0]    wdata;
  logic          resync;
  logic [7:0]    rd_data;
  logic          os_tick;
  logic          mid_tick;
  logic          bit_tick;
  logic [PW-1:0] phase;

  modport master (
    output en, ioaddr, wr, wdata, resync,
    input  rd_data, os_tick, mid_tick, bit_tick, phase
  );

  modport slave (
    input  en, ioaddr, wr, wdata, resync,
    output rd_data, os_tick, mid_tick, bit_tick, phase
  );
endinterface

// File: rtl/spart_baud_tick.sv
// Oversampled baud tick source: programmable down-counter plus phase counter,
// with byte-wise divisor staging, atomic commit and start-bit re-alignment.
module spart_baud_tick #(
  parameter int          DIV_W     = 16,
  parameter int          OSR       = 16,
  parameter logic [15:0] RESET_DIV = 16'h028A
) (
  input logic               clk,
  input logic               rst,
  spart_baud_tick_if.slave  bus
);
  localparam int         PW        = $clog2(OSR);
  localparam logic [1:0] ADDR_LOW  = 2'b10;
  localparam logic [1:0] ADDR_HIGH = 2'b11;
  localparam logic [PW-1:0] MID_PHASE = PW'(OSR / 2 - 1);
  localparam logic [PW-1:0] BIT_PHASE = PW'(OSR - 1);

  logic [7:0]       div_stage;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] cnt;
  logic [PW-1:0]    phase;

  logic             wr_low;
  logic             commit;
  logic [DIV_W-1:0] new_div;
  logic [15:0]      div_ext;
  logic             os_tick;

  assign wr_low  = bus.wr && (bus.ioaddr == ADDR_LOW);
  assign commit  = bus.wr && (bus.ioaddr == ADDR_HIGH);
  assign new_div = DIV_W'({bus.wdata, div_stage});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_stage  <= RESET_DIV[7:0];
      div_active <= DIV_W'(RESET_DIV);
    end else begin
      if (wr_low)
        div_stage <= bus.wdata;
      if (commit)
        div_active <= new_div;
    end
  end

  // Commit outranks everything so a new divisor starts cleanly even while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= DIV_W'(RESET_DIV);
      phase <= '0;
    end else if (commit) begin
      cnt   <= new_div;
      phase <= '0;
    end else if (!bus.en || bus.resync) begin
      cnt   <= div_active;
      phase <= '0;
    end else if (cnt == '0) begin
      cnt   <= div_active;
      phase <= phase + 1'b1;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

  assign os_tick      = !rst && bus.en && (cnt == '0);
  assign bus.os_tick  = os_tick;
  assign bus.mid_tick = os_tick && (phase == MID_PHASE);
  assign bus.bit_tick = os_tick && (phase == BIT_PHASE);
  assign bus.phase    = phase;

  assign div_ext = 16'(div_active);

  always_comb begin
    bus.rd_data = 8'h00;
    case (bus.ioaddr)
      ADDR_LOW:  bus.rd_data = div_ext[7:0];
      ADDR_HIGH: bus.rd_data = div_ext[15:8];
      default:   bus.rd_data = 8'h00;
    endcase
  end
endmodule
